// File: rtl/gc_ctrl_pkg.sv
// Shared types and widths for the GC-DRAM refresh controller tree.
package gc_ctrl_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    // One buffered host cycle: a write and a read issued together stay paired.
    typedef struct packed {
        logic              we;
        logic              re;
        logic [ADDR_W-1:0] waddr;
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] wdata;
    } req_slot_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: storage, wrapping pointers, occupancy, full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored. rdata always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // Storage write; contents need no reset because empty hides them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; level tracks accepted pushes minus pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/host_req_queue.sv
// Host-side request buffer in front of the refresh controller. Holds host
// requests while a refresh owns the DRAM ports and replays them in order,
// then returns read data with a registered valid strobe.
//
// Handshake: a host cycle with host_we|host_re is a push. The push is taken
// when host_ready is 1 in that same cycle; host_ready already accounts for a
// same-cycle pop, so a full queue that is draining still accepts. A push made
// while host_ready is 0 is dropped and latches overflow until reset.
import gc_ctrl_pkg::*;

module host_req_queue #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_we,
    input  logic                   host_re,
    input  logic [ADDR_W-1:0]      host_waddr,
    input  logic [ADDR_W-1:0]      host_raddr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ready,
    output logic [DATA_W-1:0]      host_rdata,
    output logic                   host_rvalid,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic                   we,
    output logic                   re,
    output logic [ADDR_W-1:0]      waddr,
    output logic [ADDR_W-1:0]      raddr,
    output logic [DATA_W-1:0]      in,
    input  logic                   busy,
    input  logic [DATA_W-1:0]      rd
);

    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int SLOT_W = $bits(req_slot_t);

    req_slot_t         push_slot;
    req_slot_t         head;
    logic [SLOT_W-1:0] head_bits;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [RD_LAT:0]   rpipe;
    logic              sample;

    assign push      = host_we | host_re;
    assign push_slot = '{we: host_we, re: host_re, waddr: host_waddr,
                         raddr: host_raddr, wdata: host_wdata};

    // busy comes straight from the controller, so the head is held in the
    // same cycle a refresh starts and nothing leaks onto the ports.
    assign pop = ~empty & ~busy;

    sync_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_slot),
        .rdata (head_bits),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign head       = req_slot_t'(head_bits);
    assign host_ready = (level < LVL_W'(DEPTH)) | pop;

    // Issue strobes only on a real pop; fields read as zero when empty.
    always_comb begin
        we    = head.we & pop;
        re    = head.re & pop;
        waddr = '0;
        raddr = '0;
        in    = '0;
        if (!empty) begin
            waddr = head.waddr;
            raddr = head.raddr;
            in    = head.wdata;
        end
    end

    // Dropped push: only when full and no pop frees a slot this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push & full & ~pop) begin
            overflow <= 1'b1;
        end
    end

    // Read-return shift pipe; stage RD_LAT is the registered valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpipe <= '0;
        end else begin
            rpipe[0] <= re;
            for (int i = 1; i <= RD_LAT; i++) begin
                rpipe[i] <= rpipe[i-1];
            end
        end
    end

    // rd is valid RD_LAT cycles after issue; pick the pipe tap at that age.
    generate
        if (RD_LAT == 0) begin : g_tap_issue
            assign sample = re;
        end else begin : g_tap_pipe
            assign sample = rpipe[RD_LAT-1];
        end
    endgenerate

    assign host_rvalid = rpipe[RD_LAT];

    // Capture controller read data on the cycle it is valid; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata <= '0;
        end else if (sample) begin
            host_rdata <= rd;
        end
    end

endmodule

// File: tb/tb_host_req_queue.sv
// Directed bench for host_req_queue (DEPTH=4, RD_LAT=1).
module tb_host_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_we;
    logic        host_re;
    logic [9:0]  host_waddr;
    logic [9:0]  host_raddr;
    logic [63:0] host_wdata;
    logic        host_ready;
    logic [63:0] host_rdata;
    logic        host_rvalid;
    logic        overflow;
    logic [2:0]  level;
    logic        we;
    logic        re;
    logic [9:0]  waddr;
    logic [9:0]  raddr;
    logic [63:0] in;
    logic        busy;
    logic [63:0] rd;

    int compared   = 0;
    int mismatched = 0;
    int issues;

    localparam logic [63:0] WDATA1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] RDPAT  = 64'hA5A5A5A5_A5A5A5A5;

    host_req_queue #(
        .DEPTH  (4),
        .RD_LAT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_we     (host_we),
        .host_re     (host_re),
        .host_waddr  (host_waddr),
        .host_raddr  (host_raddr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .overflow    (overflow),
        .level       (level),
        .we          (we),
        .re          (re),
        .waddr       (waddr),
        .raddr       (raddr),
        .in          (in),
        .busy        (busy),
        .rd          (rd)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // Driver tasks: inputs change 1 ns after the rising edge, checks 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [9:0] wa,
                         input logic [9:0] ra, input logic [63:0] wd, input logic b);
        host_we    = w;
        host_re    = r;
        host_waddr = wa;
        host_raddr = ra;
        host_wdata = wd;
        busy       = b;
    endtask

    task automatic idle(input logic b);
        drive(1'b0, 1'b0, 10'h0, 10'h0, 64'h0, b);
    endtask

    // Checker
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},  64'(level),       64'h0);
        check({tag, "_ready"},  64'(host_ready),  64'h1);
        check({tag, "_we"},     64'(we),          64'h0);
        check({tag, "_re"},     64'(re),          64'h0);
        check({tag, "_waddr"},  64'(waddr),       64'h0);
        check({tag, "_raddr"},  64'(raddr),       64'h0);
        check({tag, "_in"},     in,               64'h0);
        check({tag, "_rdata"},  host_rdata,       64'h0);
        check({tag, "_rvalid"}, 64'(host_rvalid), 64'h0);
        check({tag, "_ovf"},    64'(overflow),    64'h0);
    endtask

    initial begin
        rst = 1'b1;
        rd  = 64'h0;
        idle(1'b0);

        // Reset state
        step();
        step();
        look();
        check_reset_state("rst");
        rst = 1'b0;

        // Single write, idle controller: issues the next cycle
        step();
        drive(1'b1, 1'b0, 10'h3FF, 10'h0, WDATA1, 1'b0);
        look();
        check("w1_ready_pre", 64'(host_ready), 64'h1);
        check("w1_we_pre",    64'(we),         64'h0);
        step();
        idle(1'b0);
        look();
        check("w1_we",    64'(we),    64'h1);
        check("w1_re",    64'(re),    64'h0);
        check("w1_waddr", 64'(waddr), 64'h3FF);
        check("w1_in",    in,         WDATA1);
        check("w1_level", 64'(level), 64'h1);
        step();
        look();
        check("w1_level_after", 64'(level), 64'h0);
        check("w1_we_after",    64'(we),    64'h0);
        check("w1_waddr_after", 64'(waddr), 64'h0);

        // Busy window: writes to 1,2,3 are held, then issue in order
        step();
        drive(1'b1, 1'b0, 10'd1, 10'h0, 64'h11, 1'b0);
        look();
        step();
        drive(1'b1, 1'b0, 10'd2, 10'h0, 64'h22, 1'b1);
        look();
        check("bz1_we",    64'(we),    64'h0);
        check("bz1_waddr", 64'(waddr), 64'd1);
        check("bz1_level", 64'(level), 64'h1);
        step();
        drive(1'b1, 1'b0, 10'd3, 10'h0, 64'h33, 1'b1);
        look();
        check("bz2_we",    64'(we),    64'h0);
        check("bz2_level", 64'(level), 64'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            idle(1'b0);
            look();
            check("bz_drain_we",    64'(we),    64'h1);
            check("bz_drain_waddr", 64'(waddr), 64'(k + 1));
            check("bz_drain_in",    in,         64'(8'h11 * (k + 1)));
            check("bz_drain_level", 64'(level), 64'(3 - k));
        end
        step();
        look();
        check("bz_empty_level", 64'(level), 64'h0);

        // Paired write+read in one slot, then read return
        step();
        drive(1'b1, 1'b1, 10'd5, 10'h205, 64'h55, 1'b0);
        look();
        step();
        idle(1'b0);
        look();
        check("pair_we",    64'(we),    64'h1);
        check("pair_re",    64'(re),    64'h1);
        check("pair_waddr", 64'(waddr), 64'd5);
        check("pair_raddr", 64'(raddr), 64'h205);
        check("pair_level", 64'(level), 64'h1);
        step();
        rd = RDPAT;
        look();
        check("pair_rvalid_early", 64'(host_rvalid), 64'h0);
        step();
        rd = 64'h0;
        look();
        check("pair_rvalid", 64'(host_rvalid), 64'h1);
        check("pair_rdata",  host_rdata,       RDPAT);
        step();
        look();
        check("pair_rvalid_end", 64'(host_rvalid), 64'h0);
        check("pair_rdata_hold", host_rdata,       RDPAT);

        // Fill under busy, then push every cycle while draining
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b0, 10'(20 + k), 10'h0, 64'(k), 1'b1);
            look();
            check("fill_ready", 64'(host_ready), 64'h1);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b0, 10'(24 + k), 10'h0, 64'(k), 1'b0);
            look();
            check("fp_level", 64'(level),      64'h4);
            check("fp_ready", 64'(host_ready), 64'h1);
            check("fp_we",    64'(we),         64'h1);
            check("fp_waddr", 64'(waddr),      64'(20 + k));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            idle(1'b0);
            look();
            check("fp_drain_waddr", 64'(waddr),    64'(24 + k));
            check("fp_drain_level", 64'(level),    64'(4 - k));
            check("fp_ovf",         64'(overflow), 64'h0);
        end
        step();
        look();
        check("fp_empty_level", 64'(level),    64'h0);
        check("fp_empty_ovf",   64'(overflow), 64'h0);

        // Overflow: five pushes under busy, fifth is dropped
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b0, 10'(10 + k), 10'h0, 64'(k), 1'b1);
            look();
        end
        step();
        drive(1'b1, 1'b0, 10'd14, 10'h0, 64'h99, 1'b1);
        look();
        check("ov_ready_full", 64'(host_ready), 64'h0);
        check("ov_level_full", 64'(level),      64'h4);
        check("ov_ovf_pre",    64'(overflow),   64'h0);
        step();
        idle(1'b1);
        look();
        check("ov_ovf",   64'(overflow), 64'h1);
        check("ov_level", 64'(level),    64'h4);
        issues = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            idle(1'b0);
            look();
            if (we) begin
                check("ov_issue_waddr", 64'(waddr), 64'(10 + issues));
                issues++;
            end
        end
        check("ov_issue_count", 64'(issues),   64'd4);
        check("ov_level_end",   64'(level),    64'h0);
        check("ov_ovf_sticky",  64'(overflow), 64'h1);

        // Read issued, reset the next cycle: no return, reset values
        step();
        drive(1'b0, 1'b1, 10'h0, 10'h55, 64'h0, 1'b0);
        look();
        step();
        idle(1'b0);
        look();
        check("rr_re",    64'(re),    64'h1);
        check("rr_raddr", 64'(raddr), 64'h55);
        step();
        rst = 1'b1;
        rd  = 64'h1234_5678_9ABC_DEF0;
        look();
        step();
        rst = 1'b0;
        rd  = 64'h0;
        look();
        check_reset_state("rr");
        step();
        look();
        check("rr_rvalid_late", 64'(host_rvalid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
